// File: rtl/hazard_pkg.sv
// Shared types and helpers for the LEGv8 hazard/forwarding controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

  localparam logic [4:0] ZERO_REG = 5'd31;

  typedef struct packed {
    logic [4:0] rd;
    logic       regwrite;
    logic       memtoreg;
    logic       flagwrite;
  } shadow_stage_t;

  localparam shadow_stage_t STAGE_EMPTY = '{rd: 5'd0, regwrite: 1'b0, memtoreg: 1'b0, flagwrite: 1'b0};

  // XZR is never a producer, so a write to it can neither forward nor hazard.
  function automatic logic reg_hit(input logic [4:0] rd, input logic wr,
                                   input logic [4:0] src, input logic [4:0] zero_reg);
    return wr && (rd == src) && (src != zero_reg);
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Match/priority resolver: the nearer (newer) producer wins over the farther one.
module fwd_match #(
  parameter logic [4:0] ZERO_REG = 5'd31
) (
  input  logic [4:0]           src,
  input  logic                 src_used,
  input  logic [4:0]           near_rd,
  input  logic                 near_wr,
  input  logic [4:0]           far_rd,
  input  logic                 far_wr,
  output hazard_pkg::fwd_sel_t sel
);
  import hazard_pkg::*;

  logic near_hit;
  logic far_hit;

  always_comb begin
    near_hit = src_used && reg_hit(near_rd, near_wr, src, ZERO_REG);
    far_hit  = src_used && reg_hit(far_rd, far_wr, src, ZERO_REG);
    sel      = FWD_RF;
    if (near_hit)
      sel = FWD_MEM;
    else if (far_hit)
      sel = FWD_WB;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard detection and forwarding control for the 5-stage LEGv8 pipeline,
// tracking EX/MEM/WB destinations in a private shadow pipeline.
module hazard_ctrl #(
  parameter int unsigned CNT_W    = 16,
  parameter logic [4:0]  ZERO_REG = hazard_pkg::ZERO_REG
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rn,
  input  logic [4:0]       id_rb,
  input  logic             id_uses_rn,
  input  logic             id_uses_rb,
  input  logic [4:0]       id_rd,
  input  logic             id_regwrite,
  input  logic             id_memtoreg,
  input  logic             id_flagwrite,
  input  logic             id_reads_flags,
  input  logic             id_is_cbz,
  input  logic             id_brtaken,
  output logic             stall,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       cbz_fwd,
  output logic [CNT_W-1:0] stall_cnt
);
  import hazard_pkg::*;

  shadow_stage_t    id_stage;
  shadow_stage_t    ex_q;
  logic [4:0]       mem_rd;
  logic             mem_wr;
  logic             mem_load;
  logic [4:0]       wb_rd;
  logic             wb_wr;
  fwd_sel_t         sel_a;
  fwd_sel_t         sel_b;
  fwd_sel_t         sel_cbz;
  fwd_sel_t         fwd_a_q;
  fwd_sel_t         fwd_b_q;
  logic             load_use;
  logic             flag_haz;
  logic             cbz_haz;
  logic [CNT_W-1:0] cnt_q;

  assign id_stage = '{rd: id_rd, regwrite: id_regwrite, memtoreg: id_memtoreg, flagwrite: id_flagwrite};

  always_comb begin
    load_use = ex_q.memtoreg &&
               ((id_uses_rn && reg_hit(ex_q.rd, ex_q.regwrite, id_rn, ZERO_REG)) ||
                (id_uses_rb && reg_hit(ex_q.rd, ex_q.regwrite, id_rb, ZERO_REG)));
    flag_haz = id_reads_flags && ex_q.flagwrite;
    // CBZ resolves in ID, so it must also wait out a load that has only reached MEM.
    cbz_haz  = id_is_cbz &&
               (reg_hit(ex_q.rd, ex_q.regwrite, id_rb, ZERO_REG) ||
                (mem_load && reg_hit(mem_rd, mem_wr, id_rb, ZERO_REG)));
  end

  assign stall       = load_use | flag_haz | cbz_haz;
  assign idex_bubble = stall;
  assign ifid_flush  = id_brtaken & ~stall;

  fwd_match #(.ZERO_REG(ZERO_REG)) u_fwd_a (
    .src      (id_rn),
    .src_used (id_uses_rn),
    .near_rd  (ex_q.rd),
    .near_wr  (ex_q.regwrite),
    .far_rd   (mem_rd),
    .far_wr   (mem_wr),
    .sel      (sel_a)
  );

  fwd_match #(.ZERO_REG(ZERO_REG)) u_fwd_b (
    .src      (id_rb),
    .src_used (id_uses_rb),
    .near_rd  (ex_q.rd),
    .near_wr  (ex_q.regwrite),
    .far_rd   (mem_rd),
    .far_wr   (mem_wr),
    .sel      (sel_b)
  );

  // A load in MEM has no data yet, so only ALU results qualify as the near source.
  fwd_match #(.ZERO_REG(ZERO_REG)) u_fwd_cbz (
    .src      (id_rb),
    .src_used (1'b1),
    .near_rd  (mem_rd),
    .near_wr  (mem_wr & ~mem_load),
    .far_rd   (wb_rd),
    .far_wr   (wb_wr),
    .sel      (sel_cbz)
  );

  assign cbz_fwd = (id_is_cbz && !stall) ? sel_cbz : FWD_RF;

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q     <= STAGE_EMPTY;
      mem_rd   <= 5'd0;
      mem_wr   <= 1'b0;
      mem_load <= 1'b0;
      wb_rd    <= 5'd0;
      wb_wr    <= 1'b0;
      fwd_a_q  <= FWD_RF;
      fwd_b_q  <= FWD_RF;
      cnt_q    <= '0;
    end else begin
      ex_q     <= stall ? STAGE_EMPTY : id_stage;
      mem_rd   <= ex_q.rd;
      mem_wr   <= ex_q.regwrite;
      mem_load <= ex_q.memtoreg;
      wb_rd    <= mem_rd;
      wb_wr    <= mem_wr;
      fwd_a_q  <= stall ? FWD_RF : sel_a;
      fwd_b_q  <= stall ? FWD_RF : sel_b;
      if (stall && (cnt_q != {CNT_W{1'b1}}))
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign fwd_a     = fwd_a_q;
  assign fwd_b     = fwd_b_q;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Table-driven bench for hazard_ctrl with a scoreboard for the registered outputs.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [4:0] id_rn, id_rb, id_rd;
  logic       id_uses_rn, id_uses_rb, id_regwrite, id_memtoreg, id_flagwrite;
  logic       id_reads_flags, id_is_cbz, id_brtaken;

  logic        stall, ifid_flush, idex_bubble;
  logic [1:0]  fwd_a, fwd_b, cbz_fwd;
  logic [15:0] stall_cnt;

  logic        sat_stall, sat_flush, sat_bubble;
  logic [1:0]  sat_fa, sat_fb, sat_cbz;
  logic [3:0]  sat_cnt;

  hazard_ctrl u_dut (
    .clk(clk), .reset(reset),
    .id_rn(id_rn), .id_rb(id_rb), .id_uses_rn(id_uses_rn), .id_uses_rb(id_uses_rb),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memtoreg(id_memtoreg),
    .id_flagwrite(id_flagwrite), .id_reads_flags(id_reads_flags),
    .id_is_cbz(id_is_cbz), .id_brtaken(id_brtaken),
    .stall(stall), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .cbz_fwd(cbz_fwd), .stall_cnt(stall_cnt)
  );

  // Narrow counter copy so saturation is reachable in a short run.
  hazard_ctrl #(.CNT_W(4)) u_sat (
    .clk(clk), .reset(reset),
    .id_rn(id_rn), .id_rb(id_rb), .id_uses_rn(id_uses_rn), .id_uses_rb(id_uses_rb),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memtoreg(id_memtoreg),
    .id_flagwrite(id_flagwrite), .id_reads_flags(id_reads_flags),
    .id_is_cbz(id_is_cbz), .id_brtaken(id_brtaken),
    .stall(sat_stall), .ifid_flush(sat_flush), .idex_bubble(sat_bubble),
    .fwd_a(sat_fa), .fwd_b(sat_fb), .cbz_fwd(sat_cbz), .stall_cnt(sat_cnt)
  );

  localparam bit [7:0] U_RN = 8'h80, U_RB = 8'h40, RW = 8'h20, M2R = 8'h10;
  localparam bit [7:0] FW = 8'h08, RF = 8'h04, CBZ = 8'h02, BT = 8'h01;

  typedef struct {
    logic [4:0] rn, rb, rd;
    logic [7:0] ctl;
    logic       e_stall, e_flush;
    logic [1:0] e_cbz, e_fa, e_fb;
  } vec_t;

  typedef struct {
    logic [1:0]  fa, fb;
    logic [15:0] cnt;
    logic [3:0]  scnt;
  } exp_t;

  exp_t sbq[$];
  vec_t tv[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   exp_cnt = 0;
  int   exp_scnt = 0;

  function automatic vec_t mk(int rn, int rb, int rd, bit [7:0] c,
                              bit st, bit fl, int cz, int fa, int fb);
    vec_t v;
    v.rn = rn[4:0]; v.rb = rb[4:0]; v.rd = rd[4:0]; v.ctl = c;
    v.e_stall = st; v.e_flush = fl;
    v.e_cbz = cz[1:0]; v.e_fa = fa[1:0]; v.e_fb = fb[1:0];
    return v;
  endfunction

  function automatic vec_t nop();
    return mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 0);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic drive(input vec_t v);
    id_rn = v.rn; id_rb = v.rb; id_rd = v.rd;
    {id_uses_rn, id_uses_rb, id_regwrite, id_memtoreg,
     id_flagwrite, id_reads_flags, id_is_cbz, id_brtaken} = v.ctl;
  endtask

  task automatic step(input vec_t v, input int tag);
    exp_t e;
    @(negedge clk);
    drive(v);
    #1;
    chk($sformatf("stall[%0d]", tag), stall, v.e_stall);
    chk($sformatf("bubble[%0d]", tag), idex_bubble, v.e_stall);
    chk($sformatf("flush[%0d]", tag), ifid_flush, v.e_flush);
    chk($sformatf("cbz_fwd[%0d]", tag), cbz_fwd, v.e_cbz);
    chk($sformatf("sat_ctrl[%0d]", tag), {sat_stall, sat_flush, sat_bubble, sat_cbz},
        {v.e_stall, v.e_flush, v.e_stall, v.e_cbz});
    if (v.e_stall && exp_cnt < 65535) exp_cnt++;
    if (v.e_stall && exp_scnt < 15) exp_scnt++;
    e.fa = v.e_fa; e.fb = v.e_fb; e.cnt = exp_cnt[15:0]; e.scnt = exp_scnt[3:0];
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      chk($sformatf("sbq_empty[%0d]", tag), 1, 0);
    end else begin
      e = sbq.pop_front();
      chk($sformatf("fwd_a[%0d]", tag), fwd_a, e.fa);
      chk($sformatf("fwd_b[%0d]", tag), fwd_b, e.fb);
      chk($sformatf("stall_cnt[%0d]", tag), stall_cnt, e.cnt);
      chk($sformatf("sat_cnt[%0d]", tag), sat_cnt, e.scnt);
      chk($sformatf("sat_fwd[%0d]", tag), {sat_fa, sat_fb}, {e.fa, e.fb});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    drive(nop());
    repeat (2) @(posedge clk);
    #1;
    chk("reset_stall", stall, 0);
    chk("reset_flush", ifid_flush, 0);
    chk("reset_fwd", {fwd_a, fwd_b, cbz_fwd}, 0);
    chk("reset_cnt", stall_cnt, 0);
    @(negedge clk);
    reset = 1'b0;

    // ALU -> ALU forwarding from EX, from MEM, newest wins, unused operand
    tv.push_back(mk(2, 3, 1, U_RN|U_RB|RW|FW, 0, 0, 0, 0, 0));
    tv.push_back(mk(1, 1, 4, U_RN|U_RB|RW|FW, 0, 0, 0, 1, 1));
    repeat (3) tv.push_back(nop());
    tv.push_back(mk(2, 3, 1, U_RN|U_RB|RW, 0, 0, 0, 0, 0));
    tv.push_back(nop());
    tv.push_back(mk(1, 3, 2, U_RN|U_RB|RW, 0, 0, 0, 2, 0));
    tv.push_back(mk(4, 5, 1, U_RN|U_RB|RW, 0, 0, 0, 0, 0));
    tv.push_back(mk(4, 5, 1, U_RN|U_RB|RW, 0, 0, 0, 0, 0));
    tv.push_back(mk(1, 1, 6, U_RN|U_RB|RW, 0, 0, 0, 1, 1));
    tv.push_back(mk(1, 1, 7, U_RB|RW, 0, 0, 0, 0, 2));
    repeat (3) tv.push_back(nop());
    // load-use
    tv.push_back(mk(6, 0, 5, U_RN|RW|M2R, 0, 0, 0, 0, 0));
    tv.push_back(mk(5, 2, 7, U_RN|U_RB|RW, 1, 0, 0, 0, 0));
    tv.push_back(mk(5, 2, 7, U_RN|U_RB|RW, 0, 0, 0, 2, 0));
    repeat (3) tv.push_back(nop());
    // load then CBZ with branch taken throughout
    tv.push_back(mk(6, 0, 9, U_RN|RW|M2R, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 9, 0, U_RB|CBZ|BT, 1, 0, 0, 0, 0));
    tv.push_back(mk(0, 9, 0, U_RB|CBZ|BT, 1, 0, 0, 0, 0));
    tv.push_back(mk(0, 9, 0, U_RB|CBZ|BT, 0, 1, 2, 0, 0));
    repeat (3) tv.push_back(nop());
    // CBZ behind ALU producer: from MEM, and directly behind (stall then MEM)
    tv.push_back(mk(1, 2, 9, U_RN|U_RB|RW, 0, 0, 0, 0, 0));
    tv.push_back(nop());
    tv.push_back(mk(0, 9, 0, U_RB|CBZ, 0, 0, 1, 0, 2));
    tv.push_back(mk(1, 2, 9, U_RN|U_RB|RW, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 9, 0, U_RB|CBZ, 1, 0, 0, 0, 0));
    tv.push_back(mk(0, 9, 0, U_RB|CBZ, 0, 0, 1, 0, 2));
    repeat (3) tv.push_back(nop());
    // flag hazard then taken BLT
    tv.push_back(mk(1, 2, 0, U_RN|U_RB|RW|FW, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, RF|BT, 1, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, RF|BT, 0, 1, 0, 0, 0));
    tv.push_back(nop());
    tv.push_back(mk(0, 0, 0, RF, 0, 0, 0, 0, 0));
    repeat (3) tv.push_back(nop());
    // XZR is never forwarded nor a hazard source
    tv.push_back(mk(1, 2, 31, U_RN|U_RB|RW|FW, 0, 0, 0, 0, 0));
    tv.push_back(mk(31, 31, 3, U_RN|U_RB|RW|FW, 0, 0, 0, 0, 0));
    tv.push_back(mk(6, 0, 31, U_RN|RW|M2R, 0, 0, 0, 0, 0));
    tv.push_back(mk(31, 31, 7, U_RN|U_RB|RW, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 31, 0, U_RB|CBZ, 0, 0, 0, 0, 0));
    repeat (3) tv.push_back(nop());

    for (int i = 0; i < tv.size(); i++) step(tv[i], i);

    // reset asserted while a load-use stall is active
    step(mk(6, 0, 5, U_RN|RW|M2R, 0, 0, 0, 0, 0), 1000);
    @(negedge clk);
    drive(mk(5, 2, 7, U_RN|U_RB|RW, 0, 0, 0, 0, 0));
    #1;
    chk("rst_pre_stall", stall, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_stall", {stall, idex_bubble, ifid_flush}, 0);
    chk("rst_fwd", {fwd_a, fwd_b, cbz_fwd}, 0);
    chk("rst_cnt", stall_cnt, 0);
    chk("rst_sat_cnt", sat_cnt, 0);
    @(negedge clk);
    reset = 1'b0;
    exp_cnt = 0;
    exp_scnt = 0;

    // back-to-back load-use pairs drive the narrow counter into saturation
    for (int k = 0; k < 20; k++) begin
      step(mk(6, 0, 5, U_RN|RW|M2R, 0, 0, 0, 0, 0), 2000 + 2*k);
      step(mk(5, 2, 7, U_RN|U_RB|RW, 1, 0, 0, 0, 0), 2001 + 2*k);
    end
    chk("final_cnt", stall_cnt, 20);
    chk("final_sat_cnt", sat_cnt, 15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
